uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with a built-in transmit FIFO, fractional baud generator and configurable frame format (data bits, parity, stop bits). It replaces the fixed 8N1 / 115200 transmitter on the CPU's debug/console path. The core side pushes bytes through a valid/ready handshake. The block serialises frames back-to-back onto `uart_tx_o` without CPU involvement.

---
 rtl/uart_tx_fifo_pkg.sv | 27 ++
 rtl/uart_tx_fifo_if.sv | 23 ++
 rtl/uart_tx_fifo_sync.sv | 50 +++++
 rtl/uart_tx_fifo.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants and types for the UART transmitter.
// Frame-format encodings, FSM states and a frame-length helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_t;

  function automatic int frame_bits(
    input int data_bits,
    input int parity,
    input int stop_bits
  );
    int par;
    par = (parity != PARITY_NONE) ? 1 : 0;
    return 1 + data_bits + par + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Valid/ready write channel carrying one UART data word.
// The producer is the master; the FIFO is the slave.
interface uart_tx_fifo_if #(
  parameter int W = 8
) ();

  logic         valid;
  logic [W-1:0] data;
  logic         ready;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/uart_tx_fifo_sync.sv
// Generic single-clock FIFO with extra-MSB pointers.
// Ready on the write channel is simply not-full.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_tx_fifo_if.slave          wr,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level = wptr - rptr;

  assign wr.ready = !full;
  assign do_push  = wr.valid && !full;
  assign do_pop   = pop && !empty;
  assign rd_data  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wr.data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with transmit FIFO and fractional baud.
// Line, busy and done are registered and mutually aligned.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = PARITY_NONE,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        sys_clk_i,
  input  logic                        sys_rst_i,
  input  logic                        tx_valid_i,
  input  logic [DATA_BITS-1:0]        tx_data_i,
  output logic                        tx_ready_o,
  output logic                        uart_tx_o,
  output logic                        tx_busy_o,
  output logic                        tx_done_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);

  localparam int ACC_W = $clog2(CLK_HZ) + 1;
  localparam int SW    = ACC_W + 1;
  localparam int CW    = $clog2(DATA_BITS);

  localparam logic [SW-1:0] BAUD_W = SW'(BAUD);
  localparam logic [SW-1:0] CLK_W  = SW'(CLK_HZ);

  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

  uart_tx_state_t       state;
  uart_tx_state_t       state_nxt;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_nxt;
  logic [SW-1:0]        sum;
  logic                 tick;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_nxt;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_nxt;
  logic                 par;
  logic                 par_nxt;
  logic                 line_q;
  logic                 line_nxt;
  logic                 busy_q;
  logic                 done_q;
  logic                 done_nxt;
  logic                 pop;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_dout;
  logic                 load_par;

  uart_tx_fifo_if #(.W(DATA_BITS)) wr_if ();

  assign wr_if.valid = tx_valid_i;
  assign wr_if.data  = tx_data_i;
  assign tx_ready_o  = wr_if.ready;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sys_clk_i),
    .rst     (sys_rst_i),
    .wr      (wr_if),
    .pop     (pop),
    .rd_data (fifo_dout),
    .empty   (fifo_empty),
    .level   (fifo_level_o)
  );

  // Accumulator is pinned at zero while idle so frames
  // always begin phase-aligned.
  assign sum  = {1'b0, acc} + BAUD_W;
  assign tick = (state != ST_IDLE) && (sum >= CLK_W);

  always_comb begin
    acc_nxt = ACC_W'(sum);
    if (state == ST_IDLE) acc_nxt = '0;
    else if (tick)        acc_nxt = ACC_W'(sum - CLK_W);
  end

  assign load_par = (^fifo_dout) ^ (PARITY == PARITY_ODD);

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    par_nxt   = par;
    pop       = 1'b0;
    done_nxt  = 1'b0;
    line_nxt  = 1'b1;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shreg_nxt = fifo_dout;
          par_nxt   = load_par;
          cnt_nxt   = '0;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        line_nxt = 1'b0;
        if (tick) begin
          cnt_nxt   = '0;
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        line_nxt = shreg[0];
        if (tick) begin
          shreg_nxt = shreg >> 1;
          if (cnt == LAST_DATA) begin
            cnt_nxt   = '0;
            state_nxt = (PARITY != PARITY_NONE) ?
                        ST_PARITY : ST_STOP;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        line_nxt = par;
        if (tick) begin
          cnt_nxt   = '0;
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        line_nxt = 1'b1;
        if (tick) begin
          if (cnt == LAST_STOP) begin
            done_nxt  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
            if (!fifo_empty) begin
              pop       = 1'b1;
              shreg_nxt = fifo_dout;
              par_nxt   = load_par;
              state_nxt = ST_START;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state  <= ST_IDLE;
      acc    <= '0;
      shreg  <= '0;
      cnt    <= '0;
      par    <= 1'b0;
      line_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      shreg  <= shreg_nxt;
      cnt    <= cnt_nxt;
      par    <= par_nxt;
      line_q <= line_nxt;
      busy_q <= (state != ST_IDLE);
      done_q <= done_nxt;
    end
  end

  assign uart_tx_o = line_q;
  assign tx_busy_o = busy_q;
  assign tx_done_o = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo across five frame formats.
// Expected line waveforms come from an ideal bit-timing model.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_g;
  logic       rst_x;
  logic       vld;
  logic [7:0] dat;
  int         sel;
  int         checks = 0;
  int         passed = 0;
  int         last_low;
  int         last_busy;

  logic exp_line[$];
  logic exp_done[$];
  logic exp_busy[$];

  uart_tx_fifo_if #(.W(8)) if_a (), if_e (), if_o (), if_f ();
  uart_tx_fifo_if #(.W(7)) if_s ();

  assign if_a.valid = vld && (sel == 0);
  assign if_e.valid = vld && (sel == 1);
  assign if_o.valid = vld && (sel == 2);
  assign if_f.valid = vld && (sel == 3);
  assign if_s.valid = vld && (sel == 4);
  assign if_a.data  = dat;
  assign if_e.data  = dat;
  assign if_o.data  = dat;
  assign if_f.data  = dat;
  assign if_s.data  = dat[6:0];

  logic       line_a, busy_a, done_a;
  logic       line_e, busy_e, done_e;
  logic       line_o, busy_o, done_o;
  logic       line_f, busy_f, done_f;
  logic       line_s, busy_s, done_s;
  logic [2:0] lvl_a;
  logic [4:0] lvl_e, lvl_o, lvl_f, lvl_s;

  uart_tx_fifo #(
    .CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(8),
    .PARITY(PARITY_NONE), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_a (
    .sys_clk_i(clk), .sys_rst_i(rst_g | rst_x),
    .tx_valid_i(if_a.valid), .tx_data_i(if_a.data),
    .tx_ready_o(if_a.ready), .uart_tx_o(line_a),
    .tx_busy_o(busy_a), .tx_done_o(done_a),
    .fifo_level_o(lvl_a)
  );

  uart_tx_fifo #(
    .CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(8),
    .PARITY(PARITY_EVEN), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) u_e (
    .sys_clk_i(clk), .sys_rst_i(rst_g),
    .tx_valid_i(if_e.valid), .tx_data_i(if_e.data),
    .tx_ready_o(if_e.ready), .uart_tx_o(line_e),
    .tx_busy_o(busy_e), .tx_done_o(done_e),
    .fifo_level_o(lvl_e)
  );

  uart_tx_fifo #(
    .CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(8),
    .PARITY(PARITY_ODD), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) u_o (
    .sys_clk_i(clk), .sys_rst_i(rst_g),
    .tx_valid_i(if_o.valid), .tx_data_i(if_o.data),
    .tx_ready_o(if_o.ready), .uart_tx_o(line_o),
    .tx_busy_o(busy_o), .tx_done_o(done_o),
    .fifo_level_o(lvl_o)
  );

  uart_tx_fifo #(
    .CLK_HZ(100000000), .BAUD(115200), .DATA_BITS(8),
    .PARITY(PARITY_NONE), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) u_f (
    .sys_clk_i(clk), .sys_rst_i(rst_g),
    .tx_valid_i(if_f.valid), .tx_data_i(if_f.data),
    .tx_ready_o(if_f.ready), .uart_tx_o(line_f),
    .tx_busy_o(busy_f), .tx_done_o(done_f),
    .fifo_level_o(lvl_f)
  );

  uart_tx_fifo #(
    .CLK_HZ(1000000), .BAUD(100000), .DATA_BITS(7),
    .PARITY(PARITY_NONE), .STOP_BITS(2), .FIFO_DEPTH(16)
  ) u_s (
    .sys_clk_i(clk), .sys_rst_i(rst_g),
    .tx_valid_i(if_s.valid), .tx_data_i(if_s.data),
    .tx_ready_o(if_s.ready), .uart_tx_o(line_s),
    .tx_busy_o(busy_s), .tx_done_o(done_s),
    .fifo_level_o(lvl_s)
  );

  logic line_m, busy_m, done_m, rdy_m;
  int   lvl_m;

  always_comb begin
    line_m = 1'b1;
    busy_m = 1'b0;
    done_m = 1'b0;
    rdy_m  = 1'b0;
    lvl_m  = 0;
    case (sel)
      0: begin
        line_m = line_a; busy_m = busy_a; done_m = done_a;
        rdy_m = if_a.ready; lvl_m = int'(lvl_a);
      end
      1: begin
        line_m = line_e; busy_m = busy_e; done_m = done_e;
        rdy_m = if_e.ready; lvl_m = int'(lvl_e);
      end
      2: begin
        line_m = line_o; busy_m = busy_o; done_m = done_o;
        rdy_m = if_o.ready; lvl_m = int'(lvl_o);
      end
      3: begin
        line_m = line_f; busy_m = busy_f; done_m = done_f;
        rdy_m = if_f.ready; lvl_m = int'(lvl_f);
      end
      4: begin
        line_m = line_s; busy_m = busy_s; done_m = done_s;
        rdy_m = if_s.ready; lvl_m = int'(lvl_s);
      end
      default: ;
    endcase
  end

  // Ideal frame: bit n ends at ceil((n+1)*clk/baud) cycles.
  function automatic void add_frame(
    input logic [7:0] d, input int db, input int pm,
    input int sb, input longint ch, input longint bd
  );
    logic bits[$];
    logic p;
    longint c0, c1;
    p = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < db; i++) begin
      bits.push_back(d[i]);
      p = p ^ d[i];
    end
    if (pm == PARITY_EVEN) bits.push_back(p);
    if (pm == PARITY_ODD)  bits.push_back(!p);
    for (int i = 0; i < sb; i++) bits.push_back(1'b1);
    for (int n = 0; n < bits.size(); n++) begin
      c0 = (longint'(n) * ch + bd - 1) / bd;
      c1 = (longint'(n + 1) * ch + bd - 1) / bd;
      for (longint t = c0; t < c1; t++) begin
        exp_line.push_back(bits[n]);
        exp_done.push_back(1'b0);
        exp_busy.push_back(1'b1);
      end
    end
    exp_done[exp_done.size() - 1] = 1'b1;
  endfunction

  function automatic void idle_sample();
    exp_line.push_back(1'b1);
    exp_done.push_back(1'b0);
    exp_busy.push_back(1'b0);
  endfunction

  function automatic void reset_exp();
    exp_line.delete();
    exp_done.delete();
    exp_busy.delete();
    idle_sample();
  endfunction

  task automatic push(input logic [7:0] d, output int k);
    int g;
    g = 0;
    vld = 1'b1;
    dat = d;
    while (rdy_m !== 1'b1 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 5000) begin
      checks++;
      $display("FAIL push_ready: ready=%b want 1", rdy_m);
    end
    @(negedge clk);
    vld = 1'b0;
    k = cyc;
  endtask

  task automatic check_wave(input int start, input string name);
    int bad, first, g;
    bad = 0;
    first = -1;
    g = 0;
    last_low = 0;
    last_busy = 0;
    while (cyc < start && g < 100000) begin
      @(negedge clk);
      g++;
    end
    if (cyc != start) begin
      bad++;
      first = 0;
    end
    for (int j = 0; j < exp_line.size(); j++) begin
      if (line_m !== exp_line[j] || done_m !== exp_done[j] ||
          busy_m !== exp_busy[j]) begin
        bad++;
        if (first < 0) first = j;
      end
      if (line_m === 1'b0) last_low++;
      if (busy_m === 1'b1) last_busy++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0)
      $display("FAIL %s: %0d bad samples (first at +%0d), want 0",
               name, bad, first);
    else passed++;
  endtask

  task automatic send_one(
    input logic [7:0] d, input int db, input int pm,
    input int sb, input longint ch, input longint bd,
    input string name
  );
    int k;
    push(d, k);
    reset_exp();
    add_frame(d, db, pm, sb, ch, bd);
    idle_sample();
    check_wave(k + 1, name);
  endtask

  task automatic test_reset();
    rst_g = 1'b1;
    rst_x = 1'b0;
    vld = 1'b0;
    dat = '0;
    sel = 0;
    repeat (3) @(negedge clk);
    rst_g = 1'b0;
    for (int s = 0; s < 5; s++) begin
      sel = s;
      #1;
      checks++;
      if ({line_m, busy_m, done_m, rdy_m} !== 4'b1001 ||
          lvl_m !== 0)
        $display("FAIL reset_dut%0d: ltbdr=%b%b%b%b lvl=%0d want 1001 0",
                 s, line_m, busy_m, done_m, rdy_m, lvl_m);
      else passed++;
    end
    @(negedge clk);
  endtask

  task automatic test_single_8n1();
    sel = 0;
    #1;
    send_one(8'hA5, 8, PARITY_NONE, 1, 1000000, 100000, "a5_8n1");
    for (int i = 0; i < 3; i++)
      send_one(8'($urandom), 8, PARITY_NONE, 1, 1000000, 100000,
               "rand_8n1");
  endtask

  task automatic test_parity();
    sel = 1;
    #1;
    send_one(8'h07, 8, PARITY_EVEN, 1, 1000000, 100000, "even_07");
    for (int i = 0; i < 2; i++)
      send_one(8'($urandom), 8, PARITY_EVEN, 1, 1000000, 100000,
               "even_rand");
    sel = 2;
    #1;
    send_one(8'h07, 8, PARITY_ODD, 1, 1000000, 100000, "odd_07");
    for (int i = 0; i < 2; i++)
      send_one(8'($urandom), 8, PARITY_ODD, 1, 1000000, 100000,
               "odd_rand");
  endtask

  task automatic test_back_to_back();
    logic [7:0] w[6];
    int acc_edge[6];
    int pe[6];
    int lvl_obs[610];
    logic rdy_obs[610];
    int k1, e, bad_l, bad_r;
    sel = 0;
    #1;
    for (int i = 0; i < 6; i++) w[i] = 8'($urandom);
    push(w[0], k1);
    acc_edge[0] = k1;
    reset_exp();
    for (int i = 0; i < 6; i++)
      add_frame(w[i], 8, PARITY_NONE, 1, 1000000, 100000);
    idle_sample();
    fork
      begin
        for (int i = 1; i < 6; i++) push(w[i], acc_edge[i]);
      end
      check_wave(k1 + 1, "b2b_wave");
      begin
        for (int j = 0; j < 610; j++) begin
          lvl_obs[j] = lvl_m;
          rdy_obs[j] = rdy_m;
          @(negedge clk);
        end
      end
    join
    checks++;
    if (acc_edge[1] != k1 + 1 || acc_edge[4] != k1 + 4)
      $display("FAIL b2b_fill: edges +%0d/+%0d want +1/+4",
               acc_edge[1] - k1, acc_edge[4] - k1);
    else passed++;
    checks++;
    if (acc_edge[5] != k1 + 102)
      $display("FAIL b2b_sixth_held: edge +%0d want +102",
               acc_edge[5] - k1);
    else passed++;
    checks++;
    if (lvl_obs[4] !== 4 || rdy_obs[4] !== 1'b0)
      $display("FAIL b2b_full: lvl=%0d rdy=%b want 4 0",
               lvl_obs[4], rdy_obs[4]);
    else passed++;
    for (int i = 0; i < 5; i++) pe[i] = k1 + i;
    pe[5] = k1 + 102;
    bad_l = 0;
    bad_r = 0;
    for (int j = 0; j < 610; j++) begin
      e = 0;
      for (int i = 0; i < 6; i++) begin
        if (pe[i] <= k1 + j) e++;
        if (k1 + 1 + 100 * i <= k1 + j) e--;
      end
      if (lvl_obs[j] !== e) bad_l++;
      if (rdy_obs[j] !== (e < 4)) bad_r++;
    end
    checks++;
    if (bad_l != 0)
      $display("FAIL b2b_level_seq: %0d bad cycles want 0", bad_l);
    else passed++;
    checks++;
    if (bad_r != 0)
      $display("FAIL b2b_ready_seq: %0d bad cycles want 0", bad_r);
    else passed++;
  endtask

  task automatic test_frac_baud();
    sel = 3;
    #1;
    send_one(8'h00, 8, PARITY_NONE, 1, 100000000, 115200, "frac_00");
    checks++;
    if (last_low < 9 * 868 || last_low > 9 * 869)
      $display("FAIL frac_low_run: %0d cycles want 7812..7821",
               last_low);
    else passed++;
    checks++;
    if (last_busy != 8680 && last_busy != 8681)
      $display("FAIL frac_frame_len: %0d cycles want 8680/8681",
               last_busy);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int k, k2, s, g, hi;
    sel = 0;
    #1;
    push(8'($urandom), k);
    push(8'($urandom), k2);
    s = k + 2;
    g = 0;
    while (cyc < s + 44 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (lvl_m !== 1 || line_m === 1'bx)
      $display("FAIL mid_pre_level: lvl=%0d want 1", lvl_m);
    else passed++;
    rst_x = 1'b1;
    @(negedge clk);
    checks++;
    if (line_m !== 1'b1 || lvl_m !== 0)
      $display("FAIL mid_reset: line=%b lvl=%0d want 1 0",
               line_m, lvl_m);
    else passed++;
    rst_x = 1'b0;
    hi = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (line_m === 1'b1 && busy_m === 1'b0) hi++;
    end
    checks++;
    if (hi != 30)
      $display("FAIL mid_flushed: idle %0d of 30 want 30", hi);
    else passed++;
    send_one(8'h3C, 8, PARITY_NONE, 1, 1000000, 100000, "after_rst_3c");
  endtask

  task automatic test_7d2s();
    sel = 4;
    #1;
    send_one(8'h55, 7, PARITY_NONE, 2, 1000000, 100000, "d7s2_55");
    send_one(8'($urandom), 7, PARITY_NONE, 2, 1000000, 100000,
             "d7s2_rand");
  endtask

  initial begin
    test_reset();
    test_single_8n1();
    test_parity();
    test_back_to_back();
    test_frac_baud();
    test_reset_mid();
    test_7d2s();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
